// File: rtl/centscale_sample_fifo.sv
// centscale_sample_fifo: synchronous sample FIFO between the centre/scale stage
// and its downstream consumer. The head sample, flags and occupancy are all held
// in flops, so no output depends combinationally on an input.
// Optional feature: define CSFIFO_DROP_CNT_EN to add the saturating 16-bit
// dropped-sample counter on ovf_cnt_o.
module centscale_sample_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              GlobalReset,
  input  logic [31:0]       x_i,
  input  logic              srdyi_i,
  output logic [31:0]       x_o,
  output logic              srdyo_o,
  input  logic              drdy_i,
  output logic [ADDR_W:0]   count_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              overflow_o,
  input  logic              ovf_clr_i
`ifdef CSFIFO_DROP_CNT_EN
  ,
  output logic [15:0]       ovf_cnt_o
`endif
);

  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ZERO = (ADDR_W+1)'(0);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = (ADDR_W)'(1);

  logic [31:0]       mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W:0]   count_after_pop_s;
  logic [31:0]       x_q, x_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              ovf_q, ovf_d;
  logic              push_s, pop_s, drop_s;

  // Handshake decode, pointer/occupancy next state and next head-of-queue value.
  always_comb begin
    pop_s             = !empty_q && drdy_i;
    push_s            = srdyi_i && (!full_q || pop_s);
    drop_s            = srdyi_i && full_q && !pop_s;
    wr_ptr_d          = push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d          = pop_s  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    count_after_pop_s = pop_s ? (count_q - CNT_ONE) : count_q;
    count_d           = count_q;
    x_d               = x_q;

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    // The head only changes when it is consumed or when the queue was empty.
    // If nothing older remains, the incoming sample becomes the new head
    // directly, since it is not yet readable from memory.
    if (pop_s || empty_q) begin
      if (count_after_pop_s == CNT_ZERO) begin
        if (push_s) begin
          x_d = x_i;
        end else begin
          x_d = x_q;
        end
      end else begin
        x_d = mem_q[rd_ptr_d];
      end
    end else begin
      x_d = x_q;
    end

    full_d  = (count_d == CNT_FULL);
    empty_d = (count_d == CNT_ZERO);

    // A drop in the same cycle as a clear keeps the flag set.
    if (drop_s) begin
      ovf_d = 1'b1;
    end else if (ovf_clr_i) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Sample storage: written on accepted pushes only, never reset.
  always_ff @(posedge clk) begin
    if (push_s && GlobalReset) begin
      mem_q[wr_ptr_q] <= x_i;
    end
  end

  // Control state, registered head and flags with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!GlobalReset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= CNT_ZERO;
      x_q      <= 32'h0000_0000;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      x_q      <= x_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      ovf_q    <= ovf_d;
    end
  end

`ifdef CSFIFO_DROP_CNT_EN
  logic [15:0] ovf_cnt_q, ovf_cnt_d;

  // Dropped-sample counter: saturates, clears on ovf_clr_i, and restarts at
  // one when a drop coincides with the clear.
  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (drop_s) begin
      if (ovf_clr_i) begin
        ovf_cnt_d = 16'h0001;
      end else if (ovf_cnt_q != 16'hFFFF) begin
        ovf_cnt_d = ovf_cnt_q + 16'h0001;
      end else begin
        ovf_cnt_d = ovf_cnt_q;
      end
    end else if (ovf_clr_i) begin
      ovf_cnt_d = 16'h0000;
    end else begin
      ovf_cnt_d = ovf_cnt_q;
    end
  end

  // Dropped-sample counter register.
  always_ff @(posedge clk) begin
    if (!GlobalReset) begin
      ovf_cnt_q <= 16'h0000;
    end else begin
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  assign ovf_cnt_o = ovf_cnt_q;
`endif

  assign x_o        = x_q;
  assign srdyo_o    = !empty_q;
  assign count_o    = count_q;
  assign full_o     = full_q;
  assign empty_o    = empty_q;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_centscale_sample_fifo.sv
// Self-checking bench for centscale_sample_fifo: a table of short vectors with
// constant expectations, plus sequences for fill/drain, overflow, wrap and
// mid-operation reset. A reference queue holds every accepted sample and is
// compared against x_o whenever the FIFO holds data.
module tb_centscale_sample_fifo;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              GlobalReset;
  logic [31:0]       x_i;
  logic              srdyi_i;
  logic [31:0]       x_o;
  logic              srdyo_o;
  logic              drdy_i;
  logic [ADDR_W:0]   count_o;
  logic              full_o;
  logic              empty_o;
  logic              overflow_o;
  logic              ovf_clr_i;
`ifdef CSFIFO_DROP_CNT_EN
  logic [15:0]       ovf_cnt_o;
  int                m_cnt;
`endif

  int          errors = 0;
  int          checks = 0;
  logic [31:0] sb_q[$];
  int          m_count;
  logic        m_ovf;

  centscale_sample_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .GlobalReset(GlobalReset), .x_i(x_i), .srdyi_i(srdyi_i),
    .x_o(x_o), .srdyo_o(srdyo_o), .drdy_i(drdy_i), .count_o(count_o),
    .full_o(full_o), .empty_o(empty_o), .overflow_o(overflow_o),
    .ovf_clr_i(ovf_clr_i)
`ifdef CSFIFO_DROP_CNT_EN
    , .ovf_cnt_o(ovf_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        srdyi;
    logic [31:0] x;
    logic        drdy;
    logic        clr;
    int          exp_count;
    logic        exp_srdyo;
    logic        exp_ovf;
    logic [31:0] exp_x;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: drive at the falling edge, check the head, update model, check state.
  task automatic step(input logic s, input logic [31:0] x, input logic d, input logic c);
    logic pop, push, drop;
    @(negedge clk);
    srdyi_i = s; x_i = x; drdy_i = d; ovf_clr_i = c;
    if (m_count > 0) chk("head", x_o, sb_q[0]);
    pop  = (m_count > 0) && d;
    push = s && ((m_count < DEPTH) || pop);
    drop = s && !push;
    if (pop)  void'(sb_q.pop_front());
    if (push) sb_q.push_back(x);
    m_count = sb_q.size();
    m_ovf = drop ? 1'b1 : (c ? 1'b0 : m_ovf);
`ifdef CSFIFO_DROP_CNT_EN
    if (drop) m_cnt = c ? 1 : ((m_cnt == 65535) ? 65535 : m_cnt + 1);
    else if (c) m_cnt = 0;
`endif
    @(posedge clk); #1;
    chk("count", 32'(count_o), 32'(m_count));
    chk("srdyo", 32'(srdyo_o), 32'(m_count > 0));
    chk("full",  32'(full_o),  32'(m_count == DEPTH));
    chk("empty", 32'(empty_o), 32'(m_count == 0));
    chk("ovf",   32'(overflow_o), 32'(m_ovf));
`ifdef CSFIFO_DROP_CNT_EN
    chk("ovf_cnt", 32'(ovf_cnt_o), 32'(m_cnt));
`endif
  endtask

  // Hold reset for one edge with srdyi_i high; everything queued is discarded.
  task automatic do_reset();
    @(negedge clk);
    GlobalReset = 1'b0; srdyi_i = 1'b1; x_i = 32'hDEAD_BEEF; drdy_i = 1'b0; ovf_clr_i = 1'b0;
    @(posedge clk); #1;
    sb_q.delete(); m_count = 0; m_ovf = 1'b0;
`ifdef CSFIFO_DROP_CNT_EN
    m_cnt = 0;
    chk("rst_ovf_cnt", 32'(ovf_cnt_o), 32'd0);
`endif
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_srdyo", 32'(srdyo_o), 32'd0);
    chk("rst_empty", 32'(empty_o), 32'd1);
    chk("rst_full",  32'(full_o),  32'd0);
    chk("rst_ovf",   32'(overflow_o), 32'd0);
    @(negedge clk);
    GlobalReset = 1'b1; srdyi_i = 1'b0;
  endtask

  task automatic fill(input int base);
    for (int i = 0; i < DEPTH; i++) step(1'b1, 32'(base + i), 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 32'd0, 1'b1, 1'b0);
  endtask

  initial begin
    //           srdyi  x              drdy  clr   cnt srdyo ovf  exp_x
    vecs[0] = '{1'b1, 32'h3F80_0000, 1'b0, 1'b0, 1, 1'b1, 1'b0, 32'h3F80_0000};
    vecs[1] = '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 1, 1'b1, 1'b0, 32'h3F80_0000};
    vecs[2] = '{1'b1, 32'h4000_0000, 1'b1, 1'b0, 1, 1'b1, 1'b0, 32'h4000_0000};
    vecs[3] = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 0, 1'b0, 1'b0, 32'h0000_0000};
    vecs[4] = '{1'b0, 32'h0000_0000, 1'b1, 1'b1, 0, 1'b0, 1'b0, 32'h0000_0000};
    vecs[5] = '{1'b1, 32'hAAAA_5555, 1'b1, 1'b0, 1, 1'b1, 1'b0, 32'hAAAA_5555};
    vecs[6] = '{1'b1, 32'h0000_0001, 1'b0, 1'b0, 2, 1'b1, 1'b0, 32'hAAAA_5555};
    vecs[7] = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 1, 1'b1, 1'b0, 32'h0000_0001};
    vecs[8] = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 0, 1'b0, 1'b0, 32'h0000_0000};

    GlobalReset = 1'b0; srdyi_i = 1'b0; x_i = 32'h0; drdy_i = 1'b0; ovf_clr_i = 1'b0;
    m_count = 0; m_ovf = 1'b0;
`ifdef CSFIFO_DROP_CNT_EN
    m_cnt = 0;
`endif
    repeat (2) @(posedge clk);
    do_reset();

    // Table vectors, including the first push right after reset release.
    for (int i = 0; i < 9; i++) begin
      step(vecs[i].srdyi, vecs[i].x, vecs[i].drdy, vecs[i].clr);
      chk($sformatf("vec%0d_count", i), 32'(count_o), 32'(vecs[i].exp_count));
      chk($sformatf("vec%0d_srdyo", i), 32'(srdyo_o), 32'(vecs[i].exp_srdyo));
      chk($sformatf("vec%0d_ovf", i), 32'(overflow_o), 32'(vecs[i].exp_ovf));
      if (vecs[i].exp_srdyo) chk($sformatf("vec%0d_x", i), x_o, vecs[i].exp_x);
    end

    // Fill 1..16, then drain in order.
    fill(1);
    chk("fill_full", 32'(full_o), 32'd1);
    drain();
    chk("drain_empty", 32'(empty_o), 32'd1);

    // Overflow: full + push without pop drops, flag sticky, set beats clear.
    fill(1);
    step(1'b1, 32'd17, 1'b0, 1'b0);
    chk("ovf_set", 32'(overflow_o), 32'd1);
    chk("ovf_count16", 32'(count_o), 32'd16);
    step(1'b0, 32'd0, 1'b0, 1'b0);
    chk("ovf_sticky", 32'(overflow_o), 32'd1);
    step(1'b1, 32'd18, 1'b0, 1'b1);
    chk("ovf_set_wins", 32'(overflow_o), 32'd1);
    step(1'b0, 32'd0, 1'b0, 1'b1);
    chk("ovf_clr", 32'(overflow_o), 32'd0);

    // Full + push with simultaneous pop: accepted, 17 after 2..16.
    step(1'b1, 32'd17, 1'b1, 1'b0);
    chk("fullpp_count", 32'(count_o), 32'd16);
    chk("fullpp_ovf", 32'(overflow_o), 32'd0);
    chk("fullpp_head", x_o, 32'd2);
    drain();

    // 40 continuous pushes with a consumer that is always ready: pointers wrap.
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 32'(32'h100 + i), 1'b1, 1'b0);
      if (count_o > 1) chk("stream_count_le1", 32'(count_o), 32'd1);
    end
    chk("stream_last", x_o, 32'h127);
    drain();

    // Mid-operation reset with five queued samples.
    for (int i = 0; i < 5; i++) step(1'b1, 32'(32'h200 + i), 1'b0, 1'b0);
    chk("pre_rst_count", 32'(count_o), 32'd5);
    do_reset();
    step(1'b1, 32'h3F80_0000, 1'b0, 1'b0);
    chk("post_rst_x", x_o, 32'h3F80_0000);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/centscale_sample_fifo.md
CENTSCALE_SAMPLE_FIFO -- requirements
Module: centscale_sample_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, meaning the number of sample entries (power of two, 4..256).
REQ-002 The block SHALL have parameter ADDR_W, default 4, meaning the pointer width, equal to log2(DEPTH).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port GlobalReset, input, 1, the reset: synchronous and active-low (0 = reset).
REQ-005 The block SHALL have port x_i, input, 32, the SMC-float centred/scaled sample from the centre/scale stage.
REQ-006 The block SHALL have port srdyi_i, input, 1, meaning x_i is valid this cycle; there is no upstream stall path.
REQ-007 The block SHALL have port x_o, output, 32, the head-of-queue sample.
REQ-008 The block SHALL have port srdyo_o, output, 1, meaning x_o is valid.
REQ-009 The block SHALL have port drdy_i, input, 1, meaning the downstream consumer accepts x_o.
REQ-010 The block SHALL have port count_o, output, ADDR_W+1, the current occupancy, 0..DEPTH.
REQ-011 The block SHALL have ports full_o and empty_o, outputs, 1 each, meaning count_o==DEPTH and count_o==0 respectively.
REQ-012 The block SHALL have port overflow_o, output, 1, a sticky flag meaning a sample was dropped.
REQ-013 The block SHALL have port ovf_clr_i, input, 1, which clears overflow_o.

Function
REQ-014 The block SHALL define a push as srdyi_i==1 with (count_o<DEPTH or a pop in the same cycle).
REQ-015 The block SHALL define a pop as srdyo_o==1 and drdy_i==1.
REQ-016 On a push, the block SHALL write x_i to mem[wr_ptr] and advance wr_ptr modulo DEPTH.
REQ-017 On a pop, the block SHALL advance rd_ptr modulo DEPTH.
REQ-018 Pointer wrap from DEPTH-1 to 0 SHALL have no effect on data ordering.
REQ-019 The block SHALL drive srdyo_o = !empty_o and x_o = mem[rd_ptr], with data fully registered.
REQ-020 A sample pushed at edge N into an empty FIFO SHALL appear on x_o with srdyo_o==1 after edge N, i.e. 1-cycle latency.
REQ-021 With a simultaneous push and pop, count_o SHALL be unchanged; when full, the incoming sample SHALL be accepted, not dropped.
REQ-022 With a simultaneous push and pop when empty, no pop SHALL occur (srdyo_o==0); the push SHALL occur and count_o SHALL become 1.
REQ-023 When srdyi_i==1, count_o==DEPTH and there is no pop, the sample SHALL be discarded, memory and pointers SHALL be unchanged, and overflow_o SHALL be set at the next edge.
REQ-024 overflow_o SHALL remain set until ovf_clr_i==1 or reset; if set and clear occur in the same cycle, set SHALL win.
REQ-025 x_o SHALL hold its value while srdyo_o==1 and drdy_i==0.
REQ-026 drdy_i while empty SHALL have no effect.

Reset
REQ-027 While GlobalReset==0 at a clock edge, the block SHALL clear wr_ptr, rd_ptr and count_o to 0 and set empty_o=1, full_o=0, srdyo_o=0 and overflow_o=0; x_o is don't-care and memory is not cleared.
REQ-028 A reset asserted mid-operation SHALL discard all queued samples and ignore srdyi_i in that cycle.
REQ-029 The first push SHALL be possible in the first cycle with GlobalReset==1.

Configuration
REQ-030 With macro CSFIFO_DROP_CNT_EN defined, the block SHALL add output ovf_cnt_o [15:0] counting dropped samples.
REQ-031 ovf_cnt_o SHALL saturate at 16'hFFFF, reset to 0, and clear on ovf_clr_i unless a drop occurs in the same cycle, in which case it SHALL load 1.
REQ-032 With CSFIFO_DROP_CNT_EN undefined, the port and counter SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-033 Push 32'h3F800000 into an empty FIFO with drdy_i=0 -> next cycle srdyo_o=1, x_o=32'h3F800000, count_o=1.
REQ-034 Push 16 samples 1..16 with drdy_i=0, then hold drdy_i=1 -> full_o=1 after the 16th; pops return 1..16 in order; empty_o=1 after the 16th pop.
REQ-035 With the FIFO full, push value 17 with drdy_i=0 -> sample dropped, overflow_o=1, count_o=16, ovf_cnt_o=1 if enabled; then ovf_clr_i=1 -> overflow_o=0.
REQ-036 With the FIFO full, push 17 with drdy_i=1 in the same cycle -> no drop, count_o stays 16, and 17 emerges after 2..16.
REQ-037 Run 40 continuous pushes with drdy_i=1 every cycle -> pointers wrap twice, output order is preserved, count_o<=1 throughout.
REQ-038 With count_o=5, assert GlobalReset=0 for one cycle while srdyi_i=1 -> count_o=0, srdyo_o=0, overflow_o=0.
